// File: rtl/fan_pwm_multi_if.sv
// Per-channel duty request bus into the fan PWM driver.
// The master drives requests and enables; the PWM block is the slave.
interface fan_pwm_multi_if #(
    parameter int CHANNELS      = 2,
    parameter int DUTY_BITWIDTH = 5
);
    logic [CHANNELS*DUTY_BITWIDTH-1:0] duty_i;
    logic [CHANNELS-1:0]               duty_valid_i;
    logic [CHANNELS-1:0]               enable_i;

    modport master (output duty_i, duty_valid_i, enable_i);
    modport slave  (input  duty_i, duty_valid_i, enable_i);
endinterface

// File: rtl/fan_pwm_multi.sv
// N-channel fan PWM: shared period counter, kick-start, min clamp, stall retry.
// Define FAN_TACH_STALL_EN to build tach-based stall detection and stall_o.
module fan_pwm_multi #(
    parameter int CHANNELS      = 2,
    parameter int DUTY_BITWIDTH = 5,
    parameter int KICK_PERIODS  = 4,
    parameter int STALL_PERIODS = 8
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       clk_en_i,
    input  logic [DUTY_BITWIDTH-1:0]   period_i,
    input  logic [DUTY_BITWIDTH-1:0]   min_duty_i,
    fan_pwm_multi_if.slave             duty_if,
    input  logic [CHANNELS-1:0]        tach_i,
    output logic [CHANNELS-1:0]        pwm_o,
    output logic [CHANNELS-1:0]        stall_o,
    output logic [2*CHANNELS-1:0]      state_o,
    output logic                       period_end_o
);
    localparam int DW   = DUTY_BITWIDTH;
    localparam int MAXP = (KICK_PERIODS > STALL_PERIODS) ?
                          KICK_PERIODS : STALL_PERIODS;
    localparam int PW   = $clog2(MAXP + 1);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        KICK  = 2'd1,
        RUN   = 2'd2,
        STALL = 2'd3
    } state_t;

    logic [DW-1:0] r_cnt;
    logic          w_wrap;
    logic [DW:0]   w_top;

    assign w_wrap       = (r_cnt == period_i);
    assign period_end_o = clk_en_i && w_wrap;
    assign w_top        = {1'b0, period_i} + (DW+1)'(1);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt <= '0;
        end else if (clk_en_i) begin
            r_cnt <= w_wrap ? '0 : r_cnt + DW'(1);
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_t        r_state;
        state_t        w_state_nx;
        logic [DW-1:0] r_shadow;
        logic [DW-1:0] r_active;
        logic [DW-1:0] w_duty;
        logic [DW-1:0] w_next_act;
        logic [PW-1:0] r_pc;
        logic [PW-1:0] w_pc_nx;
        logic [DW:0]   w_req;
        logic [DW:0]   w_eff;
        logic          r_pwm;
        logic          w_pwm_nx;
        logic          w_en;
        logic          w_dv;
        logic          w_miss;
        logic          w_stall_set;

        assign w_duty = duty_if.duty_i[c*DW +: DW];
        assign w_en   = duty_if.enable_i[c];
        assign w_dv   = duty_if.duty_valid_i[c];
        // A strobe on the wrap tick bypasses the shadow register.
        assign w_next_act = w_dv ? w_duty : r_shadow;

        always_comb begin
            w_state_nx  = r_state;
            w_pc_nx     = r_pc;
            w_stall_set = 1'b0;
            if (!w_en) begin
                w_state_nx = OFF;
                w_pc_nx    = '0;
            end else if (period_end_o) begin
                if (w_next_act == '0) begin
                    w_state_nx = OFF;
                    w_pc_nx    = '0;
                end else begin
                    unique case (r_state)
                        OFF: begin
                            w_state_nx = KICK;
                            w_pc_nx    = '0;
                        end
                        KICK: begin
                            if (r_pc == PW'(KICK_PERIODS - 1)) begin
                                w_state_nx = RUN;
                                w_pc_nx    = '0;
                            end else begin
                                w_pc_nx = r_pc + PW'(1);
                            end
                        end
                        RUN: begin
                            if (!w_miss) begin
                                w_pc_nx = '0;
                            end else if (r_pc == PW'(STALL_PERIODS - 1)) begin
                                w_state_nx  = STALL;
                                w_pc_nx     = '0;
                                w_stall_set = 1'b1;
                            end else begin
                                w_pc_nx = r_pc + PW'(1);
                            end
                        end
                        STALL: begin
                            if (r_pc == PW'(STALL_PERIODS - 1)) begin
                                w_state_nx = KICK;
                                w_pc_nx    = '0;
                            end else begin
                                w_pc_nx = r_pc + PW'(1);
                            end
                        end
                    endcase
                end
            end
        end

        // Clamp to min duty, saturate at a full period; KICK is always full.
        always_comb begin
            w_req = {1'b0, r_active};
            if (r_active != '0 && r_active < min_duty_i) begin
                w_req = {1'b0, min_duty_i};
            end
            w_eff = (r_state == KICK || w_req > w_top) ? w_top : w_req;
            w_pwm_nx = w_en && (r_state == KICK || r_state == RUN)
                       && (period_i != '0) && ({1'b0, r_cnt} < w_eff);
        end

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                r_state  <= OFF;
                r_pc     <= '0;
                r_shadow <= '0;
                r_active <= '0;
                r_pwm    <= 1'b0;
            end else begin
                r_state <= w_state_nx;
                r_pc    <= w_pc_nx;
                r_pwm   <= w_pwm_nx;
                if (w_dv) begin
                    r_shadow <= w_duty;
                end
                if (period_end_o) begin
                    r_active <= w_next_act;
                end
            end
        end

        assign pwm_o[c]          = r_pwm;
        assign state_o[2*c +: 2] = r_state;

`ifdef FAN_TACH_STALL_EN
        logic r_s1;
        logic r_s2;
        logic r_s3;
        logic r_seen;
        logic r_stall;
        logic w_edge;

        assign w_edge = r_s2 & ~r_s3;
        assign w_miss = ~(r_seen | w_edge);

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                r_s1    <= 1'b0;
                r_s2    <= 1'b0;
                r_s3    <= 1'b0;
                r_seen  <= 1'b0;
                r_stall <= 1'b0;
            end else begin
                r_s1 <= tach_i[c];
                r_s2 <= r_s1;
                r_s3 <= r_s2;
                if (period_end_o) begin
                    r_seen <= 1'b0;
                end else if (w_edge) begin
                    r_seen <= 1'b1;
                end
                if (w_dv || !w_en) begin
                    r_stall <= 1'b0;
                end else if (w_stall_set) begin
                    r_stall <= 1'b1;
                end
            end
        end

        assign stall_o[c] = r_stall;
`else
        logic w_unused_tach;

        assign w_unused_tach = tach_i[c] ^ w_stall_set;
        assign w_miss        = 1'b0;
        assign stall_o[c]    = 1'b0;
`endif
    end
endmodule

// File: tb/tb_fan_pwm_multi.sv
// Directed bench for fan_pwm_multi: period 20 ticks, min duty 3.
// Stall scenario runs when FAN_TACH_STALL_EN is defined, else the no-stall one.
`timescale 1ns/1ps
module tb_fan_pwm_multi;
    localparam int CH = 2;
    localparam int DW = 5;

    logic          clk = 1'b0;
    logic          rstn;
    logic          clk_en;
    logic [DW-1:0] period;
    logic [DW-1:0] min_duty;
    logic [CH-1:0] tach = '0;
    logic [CH-1:0] pwm;
    logic [CH-1:0] stall;
    logic [2*CH-1:0] state;
    logic          pe;
    logic [CH-1:0] tach_run;
    int            tph = 0;
    int            n_pass;
    int            n_total;

    fan_pwm_multi_if #(.CHANNELS(CH), .DUTY_BITWIDTH(DW)) dif ();

    fan_pwm_multi #(
        .CHANNELS(CH), .DUTY_BITWIDTH(DW),
        .KICK_PERIODS(4), .STALL_PERIODS(8)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .clk_en_i(clk_en),
        .period_i(period), .min_duty_i(min_duty),
        .duty_if(dif), .tach_i(tach),
        .pwm_o(pwm), .stall_o(stall), .state_o(state),
        .period_end_o(pe)
    );

    always #5 clk = ~clk;

    // One tach pulse per PWM period, rising 5 ticks after the wrap.
    always @(negedge clk) begin
        tph = pe ? 0 : tph + 1;
        for (int c = 0; c < CH; c++)
            tach[c] = tach_run[c] && tph >= 5 && tph < 15;
    end

    function automatic logic [1:0] st(input int ch);
        return state[2*ch +: 2];
    endfunction

    task automatic wait_pe();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!pe && k < 100);
        n_total++;
        if (!pe) $display("FAIL wait_pe: no period_end in %0d cycles", k);
        else n_pass++;
    endtask

    task automatic strobe(input int ch, input logic [DW-1:0] d);
        @(negedge clk);
        dif.duty_i[ch*DW +: DW] = d;
        dif.duty_valid_i[ch] = 1'b1;
        @(negedge clk);
        dif.duty_valid_i[ch] = 1'b0;
    endtask

    task automatic count_hi(input int n, output int h0, output int h1);
        h0 = 0;
        h1 = 0;
        repeat (n) begin
            @(negedge clk);
            h0 += int'(pwm[0]);
            h1 += int'(pwm[1]);
        end
    endtask

    task automatic start_ch(input int ch, input logic [DW-1:0] d);
        int h0, h1, hk;
        wait_pe();
        strobe(ch, d);
        wait_pe();
        @(negedge clk);
        n_total++;
        if (st(ch) !== 2'd1)
            $display("FAIL kick_entry ch%0d: state=%0d want 1", ch, st(ch));
        else n_pass++;
        hk = 0;
        repeat (4) begin
            count_hi(20, h0, h1);
            hk += (ch == 0) ? h0 : h1;
        end
        n_total++;
        if (hk !== 80) $display("FAIL kick_high ch%0d: got %0d want 80", ch, hk);
        else n_pass++;
        n_total++;
        if (st(ch) !== 2'd2)
            $display("FAIL kick_to_run ch%0d: state=%0d want 2", ch, st(ch));
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_total++;
        if (pwm !== 2'b00) $display("FAIL rst_pwm: got %b want 00", pwm);
        else n_pass++;
        n_total++;
        if (stall !== 2'b00) $display("FAIL rst_stall: got %b want 00", stall);
        else n_pass++;
        n_total++;
        if (state !== 4'h0) $display("FAIL rst_state: got %h want 0", state);
        else n_pass++;
        n_total++;
        if (pe !== 1'b0) $display("FAIL rst_pe: got %b want 0", pe);
        else n_pass++;
        rstn = 1'b1;
    endtask

    task automatic test_period_end();
        int k;
        wait_pe();
        @(negedge clk);
        n_total++;
        if (pe !== 1'b0) $display("FAIL pe_width: got %b want 0", pe);
        else n_pass++;
        k = 1;
        while (!pe && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_total++;
        if (k !== 20) $display("FAIL pe_spacing: got %0d want 20", k);
        else n_pass++;
    endtask

    task automatic test_basic();
        int h0, h1;
        dif.enable_i[0] = 1'b1;
        start_ch(0, 5'd10);
        count_hi(20, h0, h1);
        n_total++;
        if (h0 !== 10) $display("FAIL basic_run: got %0d want 10", h0);
        else n_pass++;
        n_total++;
        if (h1 !== 0) $display("FAIL basic_ch1_idle: got %0d want 0", h1);
        else n_pass++;
        n_total++;
        if (stall !== 2'b00) $display("FAIL basic_stall: got %b want 00", stall);
        else n_pass++;
    endtask

    task automatic test_clamp();
        int h0, h1;
        wait_pe();
        strobe(0, 5'd1);
        wait_pe();
        @(negedge clk);
        count_hi(20, h0, h1);
        n_total++;
        if (h0 !== 3) $display("FAIL min_clamp: got %0d want 3", h0);
        else n_pass++;
        // Strobe exactly on the wrap tick takes effect for the next period.
        wait_pe();
        dif.duty_i[0 +: DW] = 5'd31;
        dif.duty_valid_i[0] = 1'b1;
        @(negedge clk);
        dif.duty_valid_i[0] = 1'b0;
        count_hi(20, h0, h1);
        n_total++;
        if (h0 !== 20) $display("FAIL saturate_coincident: got %0d want 20", h0);
        else n_pass++;
        wait_pe();
        strobe(0, 5'd0);
        wait_pe();
        @(negedge clk);
        n_total++;
        if (st(0) !== 2'd0) $display("FAIL zero_off: state=%0d want 0", st(0));
        else n_pass++;
        count_hi(20, h0, h1);
        n_total++;
        if (h0 !== 0) $display("FAIL zero_pwm: got %0d want 0", h0);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int ha, hb;
        start_ch(0, 5'd5);
        ha = 0;
        hb = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i < 20) ha += int'(pwm[0]);
            else hb += int'(pwm[0]);
            if (i == 10) begin
                dif.duty_i[0 +: DW] = 5'd15;
                dif.duty_valid_i[0] = 1'b1;
            end
            if (i == 11) dif.duty_valid_i[0] = 1'b0;
        end
        n_total++;
        if (ha !== 5) $display("FAIL glitch_cur: got %0d want 5", ha);
        else n_pass++;
        n_total++;
        if (hb !== 15) $display("FAIL glitch_next: got %0d want 15", hb);
        else n_pass++;
    endtask

    task automatic test_two_ch();
        int h0, h1;
        dif.enable_i[1] = 1'b1;
        start_ch(1, 5'd7);
        count_hi(20, h0, h1);
        n_total++;
        if (h0 !== 15) $display("FAIL two_ch0: got %0d want 15", h0);
        else n_pass++;
        n_total++;
        if (h1 !== 7) $display("FAIL two_ch1: got %0d want 7", h1);
        else n_pass++;
        @(negedge clk);
        dif.enable_i[1] = 1'b0;
        @(negedge clk);
        n_total++;
        if (st(1) !== 2'd0) $display("FAIL disable_state: got %0d want 0", st(1));
        else n_pass++;
        n_total++;
        if (pwm[1] !== 1'b0) $display("FAIL disable_pwm: got %b want 0", pwm[1]);
        else n_pass++;
        n_total++;
        if (st(0) !== 2'd2) $display("FAIL disable_indep: got %0d want 2", st(0));
        else n_pass++;
    endtask

`ifdef FAN_TACH_STALL_EN
    task automatic test_stall();
        int h0, h1, hs;
        wait_pe();
        tach_run[0] = 1'b0;
        repeat (7) wait_pe();
        n_total++;
        if (st(0) !== 2'd2) $display("FAIL stall_early: got %0d want 2", st(0));
        else n_pass++;
        wait_pe();
        @(negedge clk);
        n_total++;
        if (st(0) !== 2'd3) $display("FAIL stall_state: got %0d want 3", st(0));
        else n_pass++;
        n_total++;
        if (stall !== 2'b01) $display("FAIL stall_flag: got %b want 01", stall);
        else n_pass++;
        hs = 0;
        repeat (8) begin
            count_hi(20, h0, h1);
            hs += h0;
        end
        n_total++;
        if (hs !== 0) $display("FAIL stall_pwm: got %0d want 0", hs);
        else n_pass++;
        n_total++;
        if (st(0) !== 2'd1) $display("FAIL stall_retry: got %0d want 1", st(0));
        else n_pass++;
        tach_run[0] = 1'b1;
        hs = 0;
        repeat (4) begin
            count_hi(20, h0, h1);
            hs += h0;
        end
        n_total++;
        if (hs !== 80) $display("FAIL retry_kick: got %0d want 80", hs);
        else n_pass++;
        count_hi(40, h0, h1);
        n_total++;
        if (h0 !== 30) $display("FAIL retry_run: got %0d want 30", h0);
        else n_pass++;
        n_total++;
        if (st(0) !== 2'd2 || stall[0] !== 1'b1)
            $display("FAIL retry_sticky: state=%0d stall=%b want 2/1", st(0), stall[0]);
        else n_pass++;
        strobe(0, 5'd15);
        n_total++;
        if (stall[0] !== 1'b0) $display("FAIL stall_clear: got %b want 0", stall[0]);
        else n_pass++;
    endtask
`else
    task automatic test_no_stall();
        int h0, h1, bad;
        tach_run = '0;
        bad = 0;
        repeat (100) begin
            wait_pe();
            if (st(0) !== 2'd2 || stall !== 2'b00) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL no_stall_periods: got %0d bad want 0", bad);
        else n_pass++;
        @(negedge clk);
        count_hi(20, h0, h1);
        n_total++;
        if (h0 !== 15) $display("FAIL no_stall_pwm: got %0d want 15", h0);
        else n_pass++;
    endtask
`endif

    task automatic test_async_reset();
        int h0, h1;
        @(negedge clk);
        dif.enable_i[0] = 1'b0;
        @(negedge clk);
        dif.enable_i[0] = 1'b1;
        wait_pe();
        @(negedge clk);
        n_total++;
        if (st(0) !== 2'd1) $display("FAIL rekick_state: got %0d want 1", st(0));
        else n_pass++;
        count_hi(30, h0, h1);
        n_total++;
        if (pwm[0] !== 1'b1) $display("FAIL prereset_pwm: got %b want 1", pwm[0]);
        else n_pass++;
        #2 rstn = 1'b0;
        #1;
        n_total++;
        if (pwm !== 2'b00 || stall !== 2'b00 || state !== 4'h0 || pe !== 1'b0)
            $display("FAIL async_rst: pwm=%b stall=%b state=%h pe=%b want 0",
                     pwm, stall, state, pe);
        else n_pass++;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        start_ch(0, 5'd9);
        count_hi(20, h0, h1);
        n_total++;
        if (h0 !== 9) $display("FAIL post_rst_run: got %0d want 9", h0);
        else n_pass++;
    endtask

    task automatic test_period_zero();
        int h0, h1;
        @(negedge clk);
        period = '0;
        count_hi(40, h0, h1);
        n_total++;
        if (h0 !== 0) $display("FAIL p0_pwm: got %0d want 0", h0);
        else n_pass++;
        n_total++;
        if (pe !== 1'b1) $display("FAIL p0_wrap: got %b want 1", pe);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rstn = 1'b0;
        clk_en = 1'b1;
        period = 5'd19;
        min_duty = 5'd3;
        tach_run = '1;
        dif.duty_i = '0;
        dif.duty_valid_i = '0;
        dif.enable_i = '0;
        test_reset();
        test_period_end();
        test_basic();
        test_clamp();
        test_glitch();
        test_two_ch();
`ifdef FAN_TACH_STALL_EN
        test_stall();
`else
        test_no_stall();
`endif
        test_async_reset();
        test_period_zero();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
